aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule_pkg.sv | 44 ++++
 rtl/aes_key_schedule_sbox.sv | 51 +++++
 rtl/aes_key_schedule.sv | 159 +++++++++++++++
 tb/tb_aes_key_schedule.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES key-schedule definitions: key length codes, Nk/Nr lookup,
// FSM encoding and GF(2^8) xtime.
package aes_key_schedule_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_BAD = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GEN   = 2'b01,
        S_DRAIN = 2'b10
    } state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic int key_bits(input logic [1:0] kl);
        return 128 + 64 * int'(kl);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// FIPS-197 affine transform.
module aes_key_schedule_sbox
    import aes_key_schedule_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] b,
        input int         n
    );
        logic [7:0] r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // x^254 == x^-1 (and maps 0 to 0), built from x^2 * x^4 * ... * x^128
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2)
             ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    assign o_byte = sbox_f(i_byte);

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one 32-bit word per cycle, round keys
// delivered four words at a time over a valid/ready output register.
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last
);

    state_e       r_state;
    state_e       w_next;
    logic [1:0]   r_klen;
    logic [31:0]  r_win [8];
    logic [2:0]   r_slot;
    logic [5:0]   r_wcnt;
    logic [7:0]   r_rcon;
    logic [95:0]  r_acc;
    logic         r_err;
    logic         r_rk_valid;
    logic [127:0] r_rk_data;
    logic [3:0]   r_rk_index;
    logic         r_rk_last;

    logic [3:0]   w_nk;
    logic [3:0]   w_nr;
    logic         w_accept;
    logic         w_legal;
    logic         w_start_ok;
    logic [2:0]   w_prev_slot;
    logic [31:0]  w_prev;
    logic [31:0]  w_old;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_word;
    logic         w_from_key;
    logic         w_4th;
    logic         w_stall;
    logic         w_adv;
    logic         w_last_word;

    assign w_nk       = nk_of(r_klen);
    assign w_nr       = nr_of(r_klen);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_legal    = (key_len != KL_BAD) &&
                        (key_bits(key_len) <= MAX_KEY_BITS);
    assign w_start_ok = w_accept && w_legal;

    // Words live in slot (i mod Nk), so w[i-Nk] is the slot being overwritten
    assign w_prev_slot = (r_slot == 3'd0) ? 3'(w_nk - 4'd1)
                                          : r_slot - 3'd1;
    assign w_prev      = r_win[w_prev_slot];
    assign w_old       = r_win[r_slot];
    assign w_sub_in    = (r_slot == 3'd0) ? {w_prev[23:0], w_prev[31:24]}
                                          : w_prev;
    assign w_from_key  = r_wcnt < {2'b00, w_nk};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_key_schedule_sbox u_sbox (
            .i_byte (w_sub_in[8*b +: 8]),
            .o_byte (w_sub[8*b +: 8])
        );
    end

    always_comb begin
        w_word = w_prev ^ w_old;
        if (w_from_key) begin
            w_word = w_old;
        end else if (r_slot == 3'd0) begin
            w_word = w_sub ^ {r_rcon, 24'h0} ^ w_old;
        end else if (w_nk == 4'd8 && r_slot == 3'd4) begin
            w_word = w_sub ^ w_old;
        end
    end

    assign w_4th       = r_wcnt[1:0] == 2'b11;
    assign w_stall     = w_4th && r_rk_valid && !rk_ready;
    assign w_adv       = (r_state == S_GEN) && !w_stall;
    assign w_last_word = r_wcnt == {w_nr, 2'b11};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_GEN;
            S_GEN:   if (w_adv && w_last_word) w_next = S_DRAIN;
            S_DRAIN: if (r_rk_valid && rk_ready && r_rk_last)
                         w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_klen     <= 2'b00;
            r_slot     <= 3'd0;
            r_wcnt     <= 6'd0;
            r_rcon     <= 8'h01;
            r_acc      <= 96'h0;
            r_err      <= 1'b0;
            r_rk_valid <= 1'b0;
            r_rk_data  <= 128'h0;
            r_rk_index <= 4'd0;
            r_rk_last  <= 1'b0;
            for (int j = 0; j < 8; j++) r_win[j] <= 32'h0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_start_ok) begin
                r_klen <= key_len;
                r_slot <= 3'd0;
                r_wcnt <= 6'd0;
                r_rcon <= 8'h01;
                for (int j = 0; j < 8; j++)
                    r_win[j] <= key_in[255-32*j -: 32];
            end else if (w_adv) begin
                r_win[r_slot] <= w_word;
                r_slot <= (r_slot == 3'(w_nk - 4'd1)) ? 3'd0
                                                      : r_slot + 3'd1;
                r_wcnt <= r_wcnt + 6'd1;
                if (!w_from_key && r_slot == 3'd0)
                    r_rcon <= xtime(r_rcon);
                if (!w_4th)
                    r_acc <= {r_acc[63:0], w_word};
            end
            if (w_adv && w_4th) begin
                r_rk_valid <= 1'b1;
                r_rk_data  <= {r_acc, w_word};
                r_rk_index <= r_wcnt[5:2];
                r_rk_last  <= w_last_word;
            end else if (rk_ready) begin
                r_rk_valid <= 1'b0;
                r_rk_last  <= 1'b0;
            end
        end
    end

    assign busy     = r_state != S_IDLE;
    assign err      = r_err;
    assign rk_valid = r_rk_valid;
    assign rk_data  = r_rk_data;
    assign rk_index = r_rk_index;
    assign rk_last  = r_rk_last;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed FIPS-197 vectors for aes_key_schedule, with backpressure,
// illegal start, start-while-busy and mid-run reset sequences.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         err;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;

    aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .err      (err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   klen;
        logic [255:0] key;
        int           nkeys;
        logic [127:0] r1;
        logic [127:0] rlast;
        bit           bp;
        int           inj;
        int           abort_at;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] got [16];
    int           ngot;
    int           first_lat;
    bit           idx_ok, last_ok, stab_ok, gap_ok;
    bit           err_seen, busy_at0, timeout;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        bit           stalled;
        bit           done;
        logic [127:0] hd;
        logic [3:0]   hi;
        for (int k = 0; k < 16; k++) got[k] = 'x;
        key_len = v.klen;
        key_in  = v.key;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        ngot      = 0;
        first_lat = -1;
        idx_ok    = 1;
        last_ok   = 1;
        stab_ok   = 1;
        gap_ok    = 1;
        err_seen  = 0;
        stalled   = 0;
        done      = 0;
        hd        = '0;
        hi        = '0;
        busy_at0  = busy;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (v.abort_at >= 0 && rk_valid &&
                int'(rk_index) == v.abort_at) begin
                done = 1;
            end else begin
                if (stalled && !(rk_valid && rk_data == hd &&
                                 rk_index == hi))
                    stab_ok = 0;
                if (err) err_seen = 1;
                if (rk_valid && first_lat < 0) first_lat = cyc;
                if (cyc == v.inj) begin
                    start   = 1'b1;
                    key_len = 2'b10;
                    key_in  = ~v.key;
                end else begin
                    start = 1'b0;
                end
                rk_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_valid && rk_ready) begin
                    if (int'(rk_index) != ngot) idx_ok = 0;
                    if (rk_last != (ngot == v.nkeys - 1)) last_ok = 0;
                    if (!v.bp && cyc != 4 * (ngot + 1)) gap_ok = 0;
                    if (ngot < 16) got[ngot] = rk_data;
                    ngot++;
                    if (rk_last || ngot >= 16) done = 1;
                    stalled = 0;
                end else begin
                    stalled = rk_valid;
                    hd      = rk_data;
                    hi      = rk_index;
                end
                @(negedge clk);
            end
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        timeout  = !done;
    endtask

    vec_t vecs [4];
    vec_t v256_abort;
    vec_t v128;

    initial begin
        vecs[0] = '{2'b00,
            {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 11,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, -1, -1};
        vecs[1] = '{2'b01,
            {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
            13,
            128'h62f8ead2522c6b7bfe0c91f72402f5a5,
            128'he98ba06f448c773c8ecc720401002202, 1'b0, -1, -1};
        vecs[2] = '{2'b10,
            256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
            15,
            128'h1f352c073b6108d72d9810a30914dff4,
            128'hfe4890d1e6188d0b046df344706c631e, 1'b1, -1, -1};
        vecs[3] = vecs[0];
        vecs[3].inj = 6;
        v128 = vecs[0];
        v256_abort = vecs[2];
        v256_abort.bp = 1'b0;
        v256_abort.abort_at = 5;

        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'b00;
        key_in   = '0;
        rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out", {122'h0, busy, err, rk_valid, rk_last, rk_index,
                          rk_data}, 256'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {253'h0, busy, err, rk_valid}, 256'h0);

        for (int i = 0; i < 4; i++) begin
            run(vecs[i]);
            chk_i("timeout", int'(timeout), 0);
            chk_i("busy_after_start", int'(busy_at0), 1);
            chk_i("key_count", ngot, vecs[i].nkeys);
            chk_i("first_latency", first_lat, 4);
            chk("r0", 256'(got[0]), 256'(vecs[i].key[255:128]));
            chk("r1", 256'(got[1]), 256'(vecs[i].r1));
            chk("rlast", 256'(got[vecs[i].nkeys - 1]),
                256'(vecs[i].rlast));
            chk_i("index_seq", int'(idx_ok), 1);
            chk_i("last_flag", int'(last_ok), 1);
            chk_i("stall_stable", int'(stab_ok), 1);
            chk_i("key_spacing", int'(gap_ok), 1);
            chk_i("no_err", int'(err_seen), 0);
            chk("idle_after", {254'h0, busy, rk_valid}, 256'h0);
        end

        key_len = 2'b11;
        key_in  = '1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_len_err", {254'h0, err, busy}, 256'h2);
        @(negedge clk);
        chk("bad_len_after", {253'h0, err, busy, rk_valid}, 256'h0);
        repeat (6) @(negedge clk);
        chk("bad_len_stay_idle", {254'h0, busy, rk_valid}, 256'h0);

        run(v256_abort);
        chk_i("reach_r5", int'(timeout), 0);
        chk_i("r5_keys_before", ngot, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {122'h0, busy, err, rk_valid, rk_last, rk_index,
                            rk_data}, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(v128);
        chk_i("fresh_timeout", int'(timeout), 0);
        chk_i("fresh_count", ngot, 11);
        chk("fresh_r0", 256'(got[0]),
            256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
        chk("fresh_rlast", 256'(got[10]),
            256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
